// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronizes and filters ps2_clk, deserializes 11-bit frames.
// Define PS2_PARITY_CHK_EN to reject frames whose odd-parity bit is wrong.
module ps2_rx #(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] ps2_pkt_DH,
    output logic       rec_ps2_pkt,
    output logic       frame_err,
    output logic [1:0] dbg_state
);
    // Handshake: rec_ps2_pkt is a valid-only strobe with no ready; ps2_pkt_DH is
    // valid in the pulse cycle and held until the next good frame.
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // frame_err is registered, so the decision is taken one cycle early to land
    // exactly TIMEOUT_CYC cycles after the strobe cycle.
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt, filt_d;
    logic [FW-1:0] fcnt;
    logic          strobe;
    logic          par_ok;

    state_t        state_q, state_n;
    logic [2:0]    bit_q, bit_n;
    logic [7:0]    shift_q, shift_n;
    logic          par_q, par_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic [7:0]    pkt_n;
    logic          rec_n, err_n;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            filt   <= 1'b1;
            filt_d <= 1'b1;
            fcnt   <= '0;
        end else begin
            filt_d <= filt;
            if (clk_s2 == filt) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILT_LEN - 1)) begin
                filt <= clk_s2;
                fcnt <= '0;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    assign strobe = filt_d & ~filt;

`ifdef PS2_PARITY_CHK_EN
    assign par_ok = ^{shift_q, par_q};
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_n = state_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        par_n   = par_q;
        tmo_n   = tmo_q;
        pkt_n   = ps2_pkt_DH;
        rec_n   = 1'b0;
        err_n   = 1'b0;
        if (state_q == IDLE) begin
            tmo_n = '0;
            if (strobe && !dat_s2) begin
                state_n = DATA;
                bit_n   = 3'd0;
            end
        end else if (strobe) begin
            tmo_n = '0;
            case (state_q)
                DATA: begin
                    shift_n = {dat_s2, shift_q[7:1]};
                    bit_n   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                default: begin
                    state_n = IDLE;
                    if (dat_s2 && par_ok) begin
                        pkt_n = shift_q;
                        rec_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            endcase
        end else if (tmo_q == TMO_LAST) begin
            state_n = IDLE;
            err_n   = 1'b1;
            tmo_n   = '0;
            shift_n = '0;
            bit_n   = 3'd0;
        end else begin
            tmo_n = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ps2_pkt_DH  <= 8'h00;
            rec_ps2_pkt <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state_q     <= state_n;
            bit_q       <= bit_n;
            shift_q     <= shift_n;
            par_q       <= par_n;
            tmo_q       <= tmo_n;
            ps2_pkt_DH  <= pkt_n;
            rec_ps2_pkt <= rec_n;
            frame_err   <= err_n;
        end
    end

    assign dbg_state = state_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed scenarios plus randomized frames
// scored against a frame-level model (odd parity, stop bit, timeout).
`timescale 1ns/1ps
module tb_ps2_rx;
    localparam int FILT_LEN    = 4;
    localparam int TIMEOUT_CYC = 5000;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] ps2_pkt_DH;
    logic       rec_ps2_pkt;
    logic       frame_err;
    logic [1:0] dbg_state;

    ps2_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_b(rst_b), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_pkt_DH(ps2_pkt_DH), .rec_ps2_pkt(rec_ps2_pkt), .frame_err(frame_err),
        .dbg_state(dbg_state)
    );

    // 1 MHz system clock; an 80-cycle PS/2 period is 12.5 kHz
    always #500 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;
    logic [7:0] model_pkt = 8'h00;
    int         rec_cyc = -1;
    int         err_cyc = -1;
    int         last_fall = 0;
    logic       rec_d = 1'b0;
    logic       err_d = 1'b0;
    bit         parity_chk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // scoreboard: each output pulse consumes one expected event {is_err, byte}
    always @(negedge clk) begin
        if (rec_ps2_pkt || frame_err) begin
            check("exclusive", 32'(rec_ps2_pkt & frame_err), 32'd0);
            check("one_cycle", 32'((rec_ps2_pkt & rec_d) | (frame_err & err_d)), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, rec_ps2_pkt, frame_err}, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("pulse_kind", {30'd0, rec_ps2_pkt, frame_err}, exp_e[8] ? 32'd1 : 32'd2);
                if (rec_ps2_pkt) check("pkt", 32'(ps2_pkt_DH), 32'(exp_e[7:0]));
            end
            if (rec_ps2_pkt) rec_cyc = cyc;
            if (frame_err)   err_cyc = cyc;
        end
        rec_d = rec_ps2_pkt;
        err_d = frame_err;
    end

    // bits: start, 8 data LSB first, odd parity (optionally inverted), stop
    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_v,
                              input int half, input int glitch_bit, input int stop_after,
                              input int rst_after);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ par_bad, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            if (i == glitch_bit) begin
                repeat (8) @(negedge clk);
                ps2_clk = 1'b0;
                repeat (FILT_LEN - 1) @(negedge clk);
                ps2_clk = 1'b1;
                repeat (half - 8 - (FILT_LEN - 1)) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (half) @(negedge clk);
            ps2_clk = 1'b1;
            if (i == stop_after) begin
                ps2_data = 1'b1;
                return;
            end
            if (i == rst_after) begin
                @(negedge clk);
                rst_b = 1'b0;
                @(negedge clk);
                check("rst_mid_pkt", 32'(ps2_pkt_DH), 32'h00);
                check("rst_mid_rec", 32'(rec_ps2_pkt), 32'd0);
                check("rst_mid_err", 32'(frame_err), 32'd0);
                rst_b = 1'b1;
                model_pkt = 8'h00;
            end
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (half) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] b, input bit par_bad, input bit stop_v,
                            input int half, input int glitch_bit);
        bit good;
        good = stop_v && !(parity_chk && par_bad);
        exp_q.push_back({~good, b});
        send_frame(b, par_bad, stop_v, half, glitch_bit, -1, -1);
        if (good) begin
            check("rec_latency", 32'(rec_cyc), 32'(last_fall + 3 + FILT_LEN));
            model_pkt = b;
        end else begin
            check("err_latency", 32'(err_cyc), 32'(last_fall + 3 + FILT_LEN));
        end
        check("held_pkt", 32'(ps2_pkt_DH), 32'(model_pkt));
    endtask

    initial begin
`ifdef PS2_PARITY_CHK_EN
        parity_chk = 1'b1;
`else
        parity_chk = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_pkt", 32'(ps2_pkt_DH), 32'h00);
        check("rst_rec", 32'(rec_ps2_pkt), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);

        do_frame(8'h5A, 1'b0, 1'b1, 40, -1);
        do_frame(8'hE0, 1'b0, 1'b1, 40, -1);
        do_frame(8'hF0, 1'b0, 1'b1, 40, -1);
        do_frame(8'h75, 1'b0, 1'b1, 40, -1);
        do_frame(8'h5A, 1'b1, 1'b1, 40, -1);
        do_frame(8'h3C, 1'b0, 1'b0, 40, -1);

        // short low glitch while idle, then one mid-frame
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FILT_LEN - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        do_frame(8'hA5, 1'b0, 1'b1, 40, -1);
        do_frame(8'h96, 1'b0, 1'b1, 40, 3);

        // clock stops after 4 data bits
        exp_q.push_back(9'h100);
        send_frame(8'h33, 1'b0, 1'b1, 40, -1, 4, -1);
        repeat (TIMEOUT_CYC + FILT_LEN + 20) @(negedge clk);
        check("timeout_cyc", 32'(err_cyc), 32'(last_fall + 2 + FILT_LEN + TIMEOUT_CYC));
        check("timeout_pulse", 32'(exp_q.size()), 32'd0);
        do_frame(8'h1A, 1'b0, 1'b1, 40, -1);

        // reset after 5 data bits; the tail of 0xE1 is all ones and stays idle
        send_frame(8'hE1, 1'b0, 1'b1, 40, -1, -1, 5);
        check("rst_tail_pkt", 32'(ps2_pkt_DH), 32'h00);
        do_frame(8'h75, 1'b0, 1'b1, 40, -1);

        for (int k = 0; k < 12; k++) begin
            logic [7:0] rb;
            bit         rp, rs;
            int         rh;
            rb = 8'($urandom_range(0, 255));
            rp = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 7) != 0);
            rh = $urandom_range(30, 50);
            do_frame(rb, rp, rs, rh, -1);
        end

        repeat (100) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
